// File: rtl/f_pc_control_if.sv
// Fetch-side bundle between decode/hazard logic, instruction memory and the PC controller.
// The master modport belongs to the driving pipeline side, and the slave modport to f_pc_control.
interface f_pc_control_if;
  logic        i_pc_id_valid;
  logic [1:0]  i_pc_jump;
  logic [2:0]  i_pc_bop;
  logic [31:0] i_pc_rs_data;
  logic [31:0] i_pc_rt_data;
  logic [15:0] i_pc_imm;
  logic [25:0] i_pc_target;
  logic [31:0] i_pc_idpc4;
  logic        i_pc_stall;
  logic        i_pc_imem_ready;
  logic [31:0] o_pc_addr;
  logic        o_pc_valid;
  logic        o_pc_flush;
  logic        o_pc_taken;
  logic        o_pc_misalign;

  modport master (
    output i_pc_id_valid, i_pc_jump, i_pc_bop, i_pc_rs_data, i_pc_rt_data,
           i_pc_imm, i_pc_target, i_pc_idpc4, i_pc_stall, i_pc_imem_ready,
    input  o_pc_addr, o_pc_valid, o_pc_flush, o_pc_taken, o_pc_misalign
  );

  modport slave (
    input  i_pc_id_valid, i_pc_jump, i_pc_bop, i_pc_rs_data, i_pc_rt_data,
           i_pc_imm, i_pc_target, i_pc_idpc4, i_pc_stall, i_pc_imem_ready,
    output o_pc_addr, o_pc_valid, o_pc_flush, o_pc_taken, o_pc_misalign
  );
endinterface

// File: rtl/f_pc_control.sv
// Fetch PC controller: it issues fetch requests with a valid/ready handshake and resolves decode-stage redirects.
// A redirect that arrives while a fetch is outstanding is held in a pending register until the next accept.
module f_pc_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  f_pc_control_if.slave pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pendTarget_q, pendTarget_d;
  logic        pendValid_q, pendValid_d;

  logic        taken;
  logic        redirectNow;
  logic        fetchValid;
  logic        accept;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] jrTarget;
  logic [31:0] redirectTarget;

  always_comb begin
    branchTarget   = pc.i_pc_idpc4 + {{14{pc.i_pc_imm[15]}}, pc.i_pc_imm, 2'b00};
    jumpTarget     = {pc.i_pc_idpc4[31:28], pc.i_pc_target, 2'b00};
    jrTarget       = {pc.i_pc_rs_data[31:2], 2'b00};
    taken          = 1'b0;
    redirectTarget = branchTarget;
    case (pc.i_pc_jump)
      2'b00: begin
        case (pc.i_pc_bop)
          3'b001:  taken = (pc.i_pc_rs_data == pc.i_pc_rt_data);
          3'b010:  taken = (pc.i_pc_rs_data != pc.i_pc_rt_data);
          default: taken = 1'b0;
        endcase
      end
      2'b01: begin
        taken          = 1'b1;
        redirectTarget = jumpTarget;
      end
      2'b10: begin
        taken          = 1'b1;
        redirectTarget = jrTarget;
      end
      default: taken = 1'b0;
    endcase
  end

  // Gate with reset so that every combinational output reads zero while reset is held.
  assign redirectNow = ~reset & pc.i_pc_id_valid & ~pc.i_pc_stall & taken;
  assign fetchValid  = (state_q == REQ);
  assign accept      = fetchValid & pc.i_pc_imem_ready;

  assign pc.o_pc_addr     = pc_q;
  assign pc.o_pc_valid    = fetchValid;
  assign pc.o_pc_taken    = redirectNow;
  assign pc.o_pc_flush    = redirectNow | (pendValid_q & accept);
  assign pc.o_pc_misalign = redirectNow & (pc.i_pc_jump == 2'b10) & (|pc.i_pc_rs_data[1:0]);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pendValid_d  = pendValid_q;
    pendTarget_d = pendTarget_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (accept) state_d = pc.i_pc_stall ? STALL : REQ;
      STALL:   if (!pc.i_pc_stall) state_d = REQ;
      default: state_d = IDLE;
    endcase
    // An older pending redirect wins over one resolved in the same accept cycle.
    if (accept) begin
      if (pendValid_q)      pc_d = pendTarget_q;
      else if (redirectNow) pc_d = redirectTarget;
      else                  pc_d = pc_q + 32'd4;
      pendValid_d = 1'b0;
    end else if (redirectNow) begin
      pendValid_d  = 1'b1;
      pendTarget_d = redirectTarget;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pendValid_q  <= 1'b0;
      pendTarget_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pendValid_q  <= pendValid_d;
      pendTarget_q <= pendTarget_d;
    end
  end

endmodule

// File: tb/tb_f_pc_control.sv
// Scoreboard bench for f_pc_control: a behavioural model predicts each cycle's outputs into a queue,
// and a negedge monitor pops the predictions and compares them with the DUT.
module tb_f_pc_control;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic reset;
  f_pc_control_if pcIf ();

  f_pc_control #(.RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .reset(reset),
    .pc   (pcIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [31:0] addr;
    bit          taken;
    bit          flush;
    bit          mis;
  } exp_t;

  exp_t expQ[$];
  int   nTests = 0;
  int   nFails = 0;

  // The model tracks the fetch phase as follows: 0 = warm-up bubble, 1 = requesting, 2 = stalled.
  int          phase;
  logic [31:0] mPc;
  bit          mPendV;
  logic [31:0] mPendT;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nTests++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("valid", {31'd0, pcIf.o_pc_valid}, {31'd0, e.valid});
      if (e.valid) checkOutput("addr", pcIf.o_pc_addr, e.addr);
      checkOutput("taken", {31'd0, pcIf.o_pc_taken}, {31'd0, e.taken});
      checkOutput("flush", {31'd0, pcIf.o_pc_flush}, {31'd0, e.flush});
      checkOutput("misalign", {31'd0, pcIf.o_pc_misalign}, {31'd0, e.mis});
    end
  end

  // Drives one cycle (entered and left 1 time unit after a rising edge), predicts, and advances the model.
  task automatic applyStimulus(input bit idv, input logic [1:0] jmp, input logic [2:0] bop,
                               input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                               input logic [25:0] tgtField, input logic [31:0] idpc4,
                               input bit stall, input bit ready);
    bit          tk, redir, acc;
    logic [31:0] tgt;
    exp_t        e;
    pcIf.i_pc_id_valid   = idv;
    pcIf.i_pc_jump       = jmp;
    pcIf.i_pc_bop        = bop;
    pcIf.i_pc_rs_data    = rs;
    pcIf.i_pc_rt_data    = rt;
    pcIf.i_pc_imm        = imm;
    pcIf.i_pc_target     = tgtField;
    pcIf.i_pc_idpc4      = idpc4;
    pcIf.i_pc_stall      = stall;
    pcIf.i_pc_imem_ready = ready;
    tk  = 0;
    tgt = idpc4 + 32'(int'($signed(imm)) * 4);
    if (jmp == 2'd1) begin
      tk  = 1;
      tgt = (idpc4 & 32'hF000_0000) | (32'(tgtField) * 4);
    end else if (jmp == 2'd2) begin
      tk  = 1;
      tgt = rs & ~32'd3;
    end else if (jmp == 2'd0) begin
      tk = (bop == 3'd1 && rs == rt) || (bop == 3'd2 && rs != rt);
    end
    redir   = idv && !stall && tk;
    acc     = (phase == 1) && ready;
    e.valid = (phase == 1);
    e.addr  = mPc;
    e.taken = redir;
    e.flush = redir || (mPendV && acc);
    e.mis   = redir && jmp == 2'd2 && (rs % 4) != 0;
    expQ.push_back(e);
    if (acc) begin
      mPc    = mPendV ? mPendT : (redir ? tgt : mPc + 32'd4);
      mPendV = 0;
      phase  = stall ? 2 : 1;
    end else begin
      if (redir) begin
        mPendV = 1;
        mPendT = tgt;
      end
      if (phase == 0) phase = 1;
      else if (phase == 2 && !stall) phase = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input bit stall, input bit ready);
    applyStimulus(0, 2'd0, 3'd0, 32'd0, 32'd0, 16'd0, 26'd0, 32'd0, stall, ready);
  endtask

  // Asserts reset mid-cycle with a live jump on the inputs; outputs must clear without waiting for a clock edge.
  task automatic doReset();
    #2;
    pcIf.i_pc_id_valid = 1;
    pcIf.i_pc_jump     = 2'd2;
    pcIf.i_pc_rs_data  = 32'h0000_0003;
    pcIf.i_pc_stall    = 0;
    reset = 1;
    #1;
    checkOutput("rst_addr", pcIf.o_pc_addr, RESET_PC);
    checkOutput("rst_valid", {31'd0, pcIf.o_pc_valid}, 32'd0);
    checkOutput("rst_taken", {31'd0, pcIf.o_pc_taken}, 32'd0);
    checkOutput("rst_flush", {31'd0, pcIf.o_pc_flush}, 32'd0);
    checkOutput("rst_misalign", {31'd0, pcIf.o_pc_misalign}, 32'd0);
    @(posedge clk);
    #1;
    expQ.delete();
    phase  = 0;
    mPc    = RESET_PC;
    mPendV = 0;
    mPendT = 32'd0;
    reset  = 0;
  endtask

  initial begin
    reset = 0;
    pcIf.i_pc_id_valid = 0; pcIf.i_pc_jump = 0; pcIf.i_pc_bop = 0;
    pcIf.i_pc_rs_data = 0; pcIf.i_pc_rt_data = 0; pcIf.i_pc_imm = 0;
    pcIf.i_pc_target = 0; pcIf.i_pc_idpc4 = 0; pcIf.i_pc_stall = 0;
    pcIf.i_pc_imem_ready = 0;
    @(posedge clk);
    #1;
    doReset();

    // Sequential fetch straight out of reset.
    repeat (5) idleCycle(0, 1);

    // Taken beq with a negative offset, then bne with equal operands and a reserved bop.
    applyStimulus(1, 2'd0, 3'd1, 32'd5, 32'd5, 16'hFFFE, 26'd0, 32'h0000_0100, 0, 1);
    idleCycle(0, 1);
    applyStimulus(1, 2'd0, 3'd2, 32'd7, 32'd7, 16'h0010, 26'd0, 32'h0000_0200, 0, 1);
    applyStimulus(1, 2'd0, 3'd3, 32'd7, 32'd8, 16'h0010, 26'd0, 32'h0000_0200, 0, 1);
    idleCycle(0, 1);

    // A j resolved while memory is busy goes through the pending register.
    applyStimulus(1, 2'd1, 3'd0, 32'd0, 32'd0, 16'd0, 26'h0000040, 32'h9000_0010, 0, 0);
    idleCycle(0, 0);
    idleCycle(0, 0);
    idleCycle(0, 1);
    idleCycle(0, 1);

    // jr to a misaligned register value, then a jr to the top word to exercise the wrap.
    applyStimulus(1, 2'd2, 3'd0, 32'h0000_1003, 32'd0, 16'd0, 26'd0, 32'd0, 0, 1);
    idleCycle(0, 1);
    applyStimulus(1, 2'd2, 3'd0, 32'hFFFF_FFFC, 32'd0, 16'd0, 26'd0, 32'd0, 0, 1);
    repeat (3) idleCycle(0, 1);

    // A stall raised mid-request holds the handshake until accept, then the fetch parks until the stall drops.
    idleCycle(1, 0);
    idleCycle(1, 0);
    idleCycle(1, 1);
    idleCycle(1, 1);
    idleCycle(1, 1);
    idleCycle(0, 1);
    idleCycle(0, 1);
    idleCycle(1, 1);
    idleCycle(1, 0);
    doReset();
    repeat (3) idleCycle(0, 1);

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] rs, rt;
      logic [2:0]  bop;
      if (i % 400 == 399) doReset();
      rs  = $urandom;
      rt  = ($urandom_range(0, 1) == 0) ? rs : $urandom;
      bop = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
      applyStimulus($urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)), bop, rs, rt,
                    16'($urandom), 26'($urandom), $urandom & ~32'd3,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 6);
    end

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
